// File: rtl/mips_defines.sv
// Shared pipeline-control constants: hazard FSM encoding, forwarding selects,
// and the register-match rule used by forwarding and hazard detection.
package mips_defines;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DIV_WAIT = 2'd2;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  // $zero is hardwired, so it never counts as a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != '0) && (a == b);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational bypass selection for the D-stage comparator and E-stage ALU.
module forward_unit
  import mips_defines::*;
(
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteM,
  input  logic       regwriteW,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE
);

  // Youngest producer wins: M result takes precedence over W result
  always_comb begin
    forwardaD = regwriteM && reg_match(writeregM, rsD);
    forwardbD = regwriteM && reg_match(writeregM, rtD);

    forwardaE = FWD_REG;
    if (regwriteM && reg_match(writeregM, rsE))      forwardaE = FWD_M;
    else if (regwriteW && reg_match(writeregW, rsE)) forwardaE = FWD_W;

    forwardbE = FWD_REG;
    if (regwriteM && reg_match(writeregM, rtE))      forwardbE = FWD_M;
    else if (regwriteW && reg_match(writeregW, rtE)) forwardbE = FWD_W;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding, load-use/branch interlocks, and a
// small FSM sequencing multi-cycle data-memory and divider operations.
module hazard_unit
  import mips_defines::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       memtoregE,
  input  logic       memtoregM,
  input  logic       branchD,
  input  logic       jrD,
  input  logic       div_startE,
  input  logic       div_readyE,
  input  logic       memenM,
  input  logic       mem_ackM,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       stallW,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       forwardaD,
  output logic       forwardbD,
  output logic [1:0] forwardaE,
  output logic [1:0] forwardbE,
  output logic       div_go,
  output logic       mem_reqM
);

  logic [1:0] state_q, state_d;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       lwstall, brstall, memstall, divstall;
  logic       src_hit_e, src_hit_m;

  forward_unit u_forward_unit (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .forwardaD (fwd_a_d),
    .forwardbD (fwd_b_d),
    .forwardaE (fwd_a_e),
    .forwardbE (fwd_b_e)
  );

  // Single-cycle interlocks on D-stage source operands
  always_comb begin
    src_hit_e = reg_match(writeregE, rsD) || reg_match(writeregE, rtD);
    src_hit_m = reg_match(writeregM, rsD) || reg_match(writeregM, rtD);
    lwstall   = memtoregE && src_hit_e;
    brstall   = (branchD || jrD) &&
                ((regwriteE && src_hit_e) || (memtoregM && src_hit_m));
  end

  // Multi-cycle stall sources and next-state; memory beats the divider
  always_comb begin
    memstall = ((state_q == IDLE) && memenM) ||
               ((state_q == MEM_WAIT) && !mem_ackM);
    divstall = (((state_q == IDLE) && div_startE && !memenM) ||
                ((state_q == DIV_WAIT) && !div_readyE)) && !memstall;
    state_d  = state_q;
    case (state_q)
      IDLE: begin
        if (memenM)          state_d = MEM_WAIT;
        else if (div_startE) state_d = DIV_WAIT;
      end
      MEM_WAIT: if (mem_ackM)   state_d = IDLE;
      DIV_WAIT: if (div_readyE) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // State register; reset abandons any outstanding wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Merge stall/flush sources and apply the reset-time output overrides
  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    stallW    = 1'b0;
    flushD    = 1'b1;
    flushE    = 1'b1;
    flushM    = 1'b1;
    flushW    = 1'b1;
    forwardaD = 1'b0;
    forwardbD = 1'b0;
    forwardaE = FWD_REG;
    forwardbE = FWD_REG;
    div_go    = 1'b0;
    mem_reqM  = 1'b0;
    if (!rst) begin
      stallF    = memstall || divstall || lwstall || brstall;
      stallD    = stallF;
      stallE    = memstall || divstall;
      stallM    = memstall;
      flushD    = 1'b0;
      // E is held, not bubbled, while a multi-cycle op is outstanding
      flushE    = (lwstall || brstall) && !memstall && !divstall;
      flushM    = divstall;
      flushW    = memstall;
      forwardaD = fwd_a_d;
      forwardbD = fwd_b_d;
      forwardaE = fwd_a_e;
      forwardbE = fwd_b_e;
      mem_reqM  = (state_q == IDLE) && memenM;
      div_go    = (state_q == IDLE) && !memenM && div_startE;
    end
  end

endmodule
